// File: rtl/uart_tx_if.sv
// Byte-stream handshake and serial line of the uart_tx transmitter.
// master drives the byte and its valid; slave is the transmitter side.
interface uart_tx_if;
    logic [7:0] tx_din;
    logic       tx_din_vld;
    logic       tx_rdy;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_din,
        output tx_din_vld,
        input  tx_rdy,
        input  tx,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_din,
        input  tx_din_vld,
        output tx_rdy,
        output tx,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, stop; every bit lasts CLOCK_FRQ/BAUD cycles.
// Define UART_TX_PARITY_EN to insert a parity slot (sense set by PARITY_ODD) before the stop bit.
module uart_tx #(
    parameter int unsigned CLOCK_FRQ  = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned PARITY_ODD = 0
) (
    input logic     clk,
    input logic     rst_n,
    uart_tx_if.slave bus
);

    localparam int unsigned BPS  = CLOCK_FRQ / BAUD;
    localparam int unsigned CntW = (BPS > 1) ? $clog2(BPS) : 1;
    localparam logic [CntW-1:0] BpsMax = CntW'(BPS - 1);

    if (BPS < 2) begin : gen_bad_bps
        $error("uart_tx: CLOCK_FRQ/BAUD must be at least 2");
    end
    if (PARITY_ODD > 1) begin : gen_bad_parity
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_bps_q;
    logic [3:0]      cnt_bit_q;
    logic [7:0]      data_q;
    logic            tx_q;
    logic            rdy_q;
    logic            busy_q;
    logic            done_q;
    logic            bit_end;

    assign bit_end = (cnt_bps_q == BpsMax);

`ifdef UART_TX_PARITY_EN
    logic par_bit;
    assign par_bit = (^data_q) ^ PARITY_ODD[0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_bps_q <= '0;
            cnt_bit_q <= '0;
            data_q    <= '0;
            tx_q      <= 1'b1;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Bit timing runs only inside a frame; cnt_bit_q is the slot index (0 = start).
            if (state_q != StIdle) begin
                cnt_bps_q <= bit_end ? '0 : cnt_bps_q + 1'b1;
                if (bit_end) begin
                    cnt_bit_q <= cnt_bit_q + 4'd1;
                end
            end
            case (state_q)
                StIdle: begin
                    rdy_q <= 1'b1;
                    tx_q  <= 1'b1;
                    if (bus.tx_din_vld && rdy_q) begin
                        data_q    <= bus.tx_din;
                        tx_q      <= 1'b0;
                        rdy_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        cnt_bps_q <= '0;
                        cnt_bit_q <= '0;
                        state_q   <= StStart;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        tx_q    <= data_q[0];
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        if (cnt_bit_q == 4'd8) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= par_bit;
                            state_q <= StParity;
`else
                            tx_q    <= 1'b1;
                            state_q <= StStop;
`endif
                        end else begin
                            // Slot n+1 carries data bit n.
                            tx_q <= data_q[cnt_bit_q[2:0]];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (bit_end) begin
                        tx_q    <= 1'b1;
                        state_q <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (bit_end) begin
                        tx_q      <= 1'b1;
                        rdy_q     <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        cnt_bps_q <= '0;
                        cnt_bit_q <= '0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_rdy  = rdy_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at BPS=10: frame shape, handshake, reset abort, parity, loopback.
module tb_uart_tx;

    localparam int BPS = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NSLOT = 11;
`else
    localparam int NSLOT = 10;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_vec = 0;
    int n_err = 0;
    logic [7:0] rx_q[$];

    uart_tx_if bus ();

    uart_tx #(
        .CLOCK_FRQ (1000),
        .BAUD      (100),
        .PARITY_ODD(0)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

`ifdef UART_TX_PARITY_EN
    uart_tx_if bus_odd ();
    assign bus_odd.tx_din     = bus.tx_din;
    assign bus_odd.tx_din_vld = bus.tx_din_vld;

    uart_tx #(
        .CLOCK_FRQ (1000),
        .BAUD      (100),
        .PARITY_ODD(1)
    ) u_dut_odd (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_odd)
    );
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected line level for slot s of a frame carrying d.
    function automatic logic exp_bit(input logic [7:0] d, input int s, input logic odd);
        if (s == 0) return 1'b0;
        if (s <= 8) return d[s-1];
`ifdef UART_TX_PARITY_EN
        if (s == 9) return (^d) ^ odd;
`endif
        return 1'b1;
    endfunction

    // Wait for ready, present d with valid high; returns right after the accept edge.
    task automatic accept(input logic [7:0] d);
        int w;
        w = 0;
        @(negedge clk);
        while (bus.tx_rdy !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("rdy_wait", bus.tx_rdy, 1);
        bus.tx_din     = d;
        bus.tx_din_vld = 1'b1;
        @(posedge clk);
    endtask

    // mode 0: drop valid, scramble din; 1: keep valid, din -> FF then 0F; 2: stray valid 3C.
    task automatic check_frame(input logic [7:0] d, input int mode);
        int s;
        for (int k = 0; k < NSLOT * BPS; k++) begin
            @(negedge clk);
            s = k / BPS;
            check($sformatf("tx_%02h_slot%0d", d, s), bus.tx, exp_bit(d, s, 1'b0));
`ifdef UART_TX_PARITY_EN
            check($sformatf("txodd_%02h_slot%0d", d, s), bus_odd.tx, exp_bit(d, s, 1'b1));
`endif
            check("busy_in_frame", bus.tx_busy, 1);
            check("done_in_frame", bus.tx_done, 0);
            if (mode == 1) begin
                if (k == 30) bus.tx_din = 8'hFF;
                if (k == NSLOT * BPS - 5) bus.tx_din = 8'h0F;
            end else begin
                if (k == 0) bus.tx_din_vld = 1'b0;
                if (k == 20) bus.tx_din = ~d;
                if (mode == 2 && k == 40) begin
                    bus.tx_din     = 8'h3C;
                    bus.tx_din_vld = 1'b1;
                end
                if (mode == 2 && k == 41) bus.tx_din_vld = 1'b0;
            end
        end
        @(negedge clk);
        check("done_pulse", bus.tx_done, 1);
        check("busy_end", bus.tx_busy, 0);
        check("rdy_end", bus.tx_rdy, 1);
        check("tx_end", bus.tx, 1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k % 10 == 9) begin
                check("idle_tx", bus.tx, 1);
                check("idle_busy", bus.tx_busy, 0);
                check("idle_done", bus.tx_done, 0);
            end
        end
    endtask

    // Independent receiver: detect start, sample each bit mid-slot, require a high stop bit.
    initial begin : rx_model
        logic [7:0] b;
        b = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.tx === 1'b0) begin
                repeat (BPS / 2 - 1) @(negedge clk);
                if (bus.tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (BPS) @(negedge clk);
                        b[i] = bus.tx;
                    end
                    repeat ((NSLOT - 9) * BPS) @(negedge clk);
                    if (bus.tx === 1'b1) rx_q.push_back(b);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] lb [3];
        lb[0] = 8'h00;
        lb[1] = 8'hFF;
        lb[2] = 8'h5A;
        bus.tx_din     = '0;
        bus.tx_din_vld = 1'b0;
        rst_n          = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tx", bus.tx, 1);
        check("rst_rdy", bus.tx_rdy, 0);
        check("rst_busy", bus.tx_busy, 0);
        check("rst_done", bus.tx_done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", bus.tx_rdy, 1);

        // Single byte.
        accept(8'hA5);
        check_frame(8'hA5, 0);
        idle(20);

        // Valid held across two frames; second start follows the ready edge.
        accept(8'h55);
        check_frame(8'h55, 1);
        @(posedge clk);
        check_frame(8'h0F, 0);
        idle(30);

        // Request while busy is dropped.
        accept(8'h96);
        check_frame(8'h96, 2);
        idle(30);

        // Parity-sensitive byte (plain 8N1 in the default build).
        accept(8'h07);
        check_frame(8'h07, 0);
        idle(20);

        // Reset during data bit 3 of 8'h00.
        accept(8'h00);
        for (int k = 0; k < 44; k++) begin
            @(negedge clk);
            if (k == 0) bus.tx_din_vld = 1'b0;
            check($sformatf("abort_slot%0d", k / BPS), bus.tx, exp_bit(8'h00, k / BPS, 1'b0));
        end
        rst_n = 1'b0;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            check("abort_tx", bus.tx, 1);
            check("abort_rdy", bus.tx_rdy, 0);
            check("abort_busy", bus.tx_busy, 0);
            check("abort_done", bus.tx_done, 0);
        end
        rst_n = 1'b1;
        for (int r = 0; r < 15; r++) begin
            @(negedge clk);
            check("post_abort_done", bus.tx_done, 0);
            check("post_abort_tx", bus.tx, 1);
        end
        check("post_abort_rdy", bus.tx_rdy, 1);
        accept(8'h81);
        check_frame(8'h81, 0);
        idle(150);

        // Loopback through the receiver model.
        rx_q.delete();
        for (int i = 0; i < 3; i++) begin
            accept(lb[i]);
            check_frame(lb[i], 0);
        end
        idle(20);
        check("rx_count", rx_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < rx_q.size()) check($sformatf("rx_byte%0d", i), rx_q[i], lb[i]);
            else check($sformatf("rx_byte%0d_missing", i), 0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
